// File: rtl/video_clk_rst_seq_pkg.sv
// video_clk_rst_seq_pkg: state encodings and default timing for the pixel-clock bring-up sequencer
package video_clk_rst_seq_pkg;
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;
  localparam int LOCK_STABLE_DEF = 16;
  localparam int DIV_SETTLE_DEF  = 32;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/video_clk_rst_seq_sync_2ff.sv
// video_clk_rst_seq_sync_2ff: async-reset two-flop synchroniser for a single-bit level
module video_clk_rst_seq_sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end
  assign o_q = r_q;
endmodule

// File: rtl/video_clk_rst_seq.sv
// video_clk_rst_seq: PLL-lock debounce, CLKDIV reset release, settle wait, then video reset release
module video_clk_rst_seq
  import video_clk_rst_seq_pkg::*;
#(
  parameter int LOCK_STABLE = LOCK_STABLE_DEF,
  parameter int DIV_SETTLE  = DIV_SETTLE_DEF,
  parameter int CNT_W       = 8
) (
  input  logic             i_hclkin,
  input  logic             i_resetn,
  input  logic             i_pll_lock,
  input  logic             i_soft_rst,
  output logic             o_clkdiv_resetn,
  output logic             o_video_resetn,
  output logic             o_ready,
  output logic [CNT_W-1:0] o_lock_loss_cnt
);
  localparam int CW = $clog2(max2(LOCK_STABLE, DIV_SETTLE));
  localparam logic [CW-1:0] LS_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] DS_LAST = CW'(DIV_SETTLE - 1);
  logic             w_lock_s;
  state_t           r_state, w_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_loss;
  logic             r_clkdiv_resetn, r_video_resetn, r_ready;
  logic [CNT_W-1:0] r_loss_cnt;
  video_clk_rst_seq_sync_2ff u_sync (
    .i_clk  (i_hclkin),
    .i_rst_n(i_resetn),
    .i_d    (i_pll_lock),
    .o_q    (w_lock_s)
  );
  always_ff @(posedge i_hclkin or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state         <= ST_WAIT_LOCK;
      r_cnt           <= '0;
      r_clkdiv_resetn <= 1'b0;
      r_video_resetn  <= 1'b0;
      r_ready         <= 1'b0;
      r_loss_cnt      <= '0;
    end else begin
      r_state         <= w_nxt;
      r_cnt           <= w_cnt_nxt;
      r_clkdiv_resetn <= (w_nxt == ST_SETTLE) || (w_nxt == ST_RUN);
      r_video_resetn  <= (w_nxt == ST_RUN);
      r_ready         <= (w_nxt == ST_RUN);
      if (w_loss && (r_loss_cnt != '1)) r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end
  // soft_rst outranks lock loss so a simultaneous pair never counts as a loss
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt + 1'b1;
    w_loss    = 1'b0;
    if (i_soft_rst) begin
      w_nxt     = ST_WAIT_LOCK;
      w_cnt_nxt = '0;
    end else if ((r_state != ST_WAIT_LOCK) && !w_lock_s) begin
      w_nxt     = ST_WAIT_LOCK;
      w_cnt_nxt = '0;
      w_loss    = (r_state == ST_SETTLE) || (r_state == ST_RUN);
    end else if (r_state == ST_WAIT_LOCK) begin
      w_nxt     = w_lock_s ? ST_STABLE : ST_WAIT_LOCK;
      w_cnt_nxt = '0;
    end else if ((r_state == ST_STABLE) && (r_cnt == LS_LAST)) begin
      w_nxt     = ST_SETTLE;
      w_cnt_nxt = '0;
    end else if ((r_state == ST_SETTLE) && (r_cnt == DS_LAST)) begin
      w_nxt     = ST_RUN;
      w_cnt_nxt = '0;
    end else if (r_state == ST_RUN) begin
      w_cnt_nxt = '0;
    end
  end
  assign o_clkdiv_resetn = r_clkdiv_resetn;
  assign o_video_resetn  = r_video_resetn;
  assign o_ready         = r_ready;
  assign o_lock_loss_cnt = r_loss_cnt;
endmodule

// File: tb/tb_video_clk_rst_seq.sv
// tb_video_clk_rst_seq: scoreboard bench; stimulus queues expected outputs per edge, monitor compares
module tb_video_clk_rst_seq;
  typedef struct {
    int         cyc;
    logic [2:0] outs;
    logic [7:0] cnt;
    string      name;
  } exp_t;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_lock = 1'b0;
  logic       soft_rst = 1'b0;
  logic       clkdiv_resetn, video_resetn, ready;
  logic [7:0] lock_loss_cnt;
  int         n_edge = 0;
  int         base = 0;
  int         n_pass = 0;
  int         n_chk = 0;
  int         exp_cnt = 0;
  exp_t       q[$];
  video_clk_rst_seq #(.LOCK_STABLE(16), .DIV_SETTLE(32), .CNT_W(8)) dut (
    .i_hclkin       (clk),
    .i_resetn       (resetn),
    .i_pll_lock     (pll_lock),
    .i_soft_rst     (soft_rst),
    .o_clkdiv_resetn(clkdiv_resetn),
    .o_video_resetn (video_resetn),
    .o_ready        (ready),
    .o_lock_loss_cnt(lock_loss_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) n_edge <= n_edge + 1;
  function automatic void check(string nm, logic [10:0] act, logic [10:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got div/vid/rdy=%b cnt=%0d, expected div/vid/rdy=%b cnt=%0d",
                  nm, act[10:8], act[7:0], expv[10:8], expv[7:0]);
  endfunction
  // k counts edges from the first edge that samples the inputs driven at 'base'
  function automatic void expect_at(int k, logic [2:0] outs, int cnt, string nm);
    exp_t e;
    e.cyc  = base + 1 + k;
    e.outs = outs;
    e.cnt  = 8'(cnt);
    e.name = nm;
    q.push_back(e);
  endfunction
  task automatic wait_k(int k);
    while (n_edge < base + 1 + k) @(negedge clk);
  endtask
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= n_edge) begin
      exp_t e;
      e = q.pop_front();
      check((e.cyc == n_edge) ? e.name : {e.name, "_late"},
            {clkdiv_resetn, video_resetn, ready, lock_loss_cnt}, {e.outs, e.cnt});
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    base = n_edge;
    expect_at(0, 3'b000, 0, "reset_state");
    wait_k(1);
    base = n_edge;
    resetn = 1'b1;
    pll_lock = 1'b1;
    expect_at(17, 3'b000, 0, "t1_pre_div");
    expect_at(18, 3'b100, 0, "t1_div_rel");
    expect_at(49, 3'b100, 0, "t1_pre_vid");
    expect_at(50, 3'b111, 0, "t1_run");
    wait_k(52);
    base = n_edge;
    pll_lock = 1'b0;
    exp_cnt = 1;
    expect_at(1, 3'b111, 0, "t3_hold");
    expect_at(2, 3'b000, exp_cnt, "t3_drop");
    wait_k(5);
    base = n_edge;
    pll_lock = 1'b1;
    expect_at(17, 3'b000, exp_cnt, "t3_pre_div");
    expect_at(18, 3'b100, exp_cnt, "t3_div_rel");
    expect_at(49, 3'b100, exp_cnt, "t3_pre_vid");
    expect_at(50, 3'b111, exp_cnt, "t3_run");
    wait_k(52);
    base = n_edge;
    soft_rst = 1'b1;
    expect_at(0, 3'b000, exp_cnt, "t4_soft_drop");
    wait_k(0);
    soft_rst = 1'b0;
    expect_at(16, 3'b000, exp_cnt, "t4_pre_div");
    expect_at(17, 3'b100, exp_cnt, "t4_div_rel");
    expect_at(48, 3'b100, exp_cnt, "t4_pre_vid");
    expect_at(49, 3'b111, exp_cnt, "t4_run");
    wait_k(51);
    base = n_edge;
    pll_lock = 1'b0;
    expect_at(1, 3'b111, exp_cnt, "t4b_hold");
    wait_k(1);
    soft_rst = 1'b1;
    expect_at(2, 3'b000, exp_cnt, "t4b_soft_and_loss");
    wait_k(2);
    soft_rst = 1'b0;
    expect_at(5, 3'b000, exp_cnt, "t4b_idle");
    wait_k(5);
    base = n_edge;
    pll_lock = 1'b1;
    expect_at(18, 3'b000, exp_cnt, "t2_no_early");
    expect_at(28, 3'b000, exp_cnt, "t2_pre_div");
    expect_at(29, 3'b100, exp_cnt, "t2_div_rel");
    expect_at(60, 3'b100, exp_cnt, "t2_pre_vid");
    expect_at(61, 3'b111, exp_cnt, "t2_run");
    wait_k(9);
    pll_lock = 1'b0;
    wait_k(10);
    pll_lock = 1'b1;
    wait_k(63);
    for (int i = 0; i < 300; i++) begin
      base = n_edge;
      pll_lock = 1'b0;
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      expect_at(2, 3'b000, exp_cnt, "t5_loss");
      wait_k(2);
      base = n_edge;
      pll_lock = 1'b1;
      expect_at(50, 3'b111, exp_cnt, "t5_run");
      wait_k(50);
    end
    base = n_edge;
    pll_lock = 1'b0;
    expect_at(2, 3'b000, 255, "t6_sat");
    wait_k(2);
    base = n_edge;
    pll_lock = 1'b1;
    expect_at(25, 3'b100, 255, "t6_settle");
    wait_k(25);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_rst", {clkdiv_resetn, video_resetn, ready, lock_loss_cnt}, 11'd0);
    @(negedge clk);
    base = n_edge;
    resetn = 1'b1;
    expect_at(17, 3'b000, 0, "t6_pre_div");
    expect_at(18, 3'b100, 0, "t6_div_rel");
    expect_at(50, 3'b111, 0, "t6_run");
    for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      $display("FAIL %s: got no sample, expected one at edge %0d", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
